lcd_read_ctrl: RTL and testbench
================================

// Module: lcd_read_ctrl
// PURPOSE
//  Read-side companion to the LCD write strobe controller: runs 8080-style read cycles
//  (cs/rd/rs) on the parallel LCD bus. Samples lcd_db_i and returns it to the bus bridge.
//  Sits between the AHB LCD peripheral register block and the panel pins, sharing cs/rs with the writer.
//  lcd_db_oe_o is the bus-turnaround request to the pad mux.
// PARAMETERS
//  DATA_W       16  LCD data bus width
//  RD_LOW_CYC    3  clk cycles lcd_rd held low per strobe (>=1)
//  RD_HIGH_CYC   2  clk cycles lcd_rd held high after strobe, cs still low (>=1)
// PORTS
//  clk          in   1       system clock
//  rstn         in   1       reset, asynchronous, active-low
//  req_i        in   1       start read; accepted only when busy_o=0
//  rs_i         in   1       0 = command/status read, 1 = GRAM data read
//  dummy_i      in   1       prepend discarded dummy read (LCD_RD_DUMMY_EN only)
//  busy_o       out  1       transaction in progress
//  rdata_o      out  DATA_W  last read data, held until next valid
//  rvalid_o     out  1       one-cycle pulse, rdata_o updated
//  lcd_db_i     in   DATA_W  panel data bus (input path)
//  lcd_db_oe_o  out  1       0 = release bus to panel during read
//  lcd_cs       out  1       chip select, active-low
//  lcd_rd       out  1       read strobe, active-low
//  lcd_rs       out  1       register select
// BEHAVIOUR
//  - Reset: lcd_cs=1, lcd_rd=1, lcd_rs=1, lcd_db_oe_o=1, busy_o=0, rvalid_o=0, rdata_o=0, state=IDLE.
//  - All outputs registered; counter width $clog2(max(RD_LOW_CYC,RD_HIGH_CYC)+1).
//  - FSM: IDLE -> SETUP -> RD_LOW -> RD_HIGH -> IDLE.
//  - IDLE: if req_i, latch rs_i (and dummy_i); next cycle busy_o=1, enter SETUP.
//  - SETUP (1 cyc): lcd_cs=0, lcd_rs=latched rs, lcd_db_oe_o=0, lcd_rd=1.
//  - RD_LOW (RD_LOW_CYC cyc): lcd_rd=0; lcd_db_i captured on last RD_LOW cycle edge.
//  - RD_HIGH (RD_HIGH_CYC cyc): lcd_rd=1, lcd_cs=0; on exit capture commits.
//  - Exit to IDLE: lcd_cs=1, lcd_db_oe_o=1, busy_o=0; same cycle rvalid_o=1, rdata_o=captured.
//  - busy_o high for exactly 1+RD_LOW_CYC+RD_HIGH_CYC cycles per strobe.
//  - Latency req_i edge -> rvalid_o: 2+RD_LOW_CYC+RD_HIGH_CYC cycles (7 at defaults).
//  - req_i while busy_o=1: ignored, no queueing. req_i in the rvalid_o cycle: accepted (back-to-back).
//  - rs_i/dummy_i changes during busy: no effect; only values latched at acceptance count.
//  - rstn low mid-transaction: outputs return to reset values at once; no rvalid_o; rdata_o cleared.
// CONFIGURATION
//  LCD_RD_DUMMY_EN defined:
//    - dummy_i=1 at acceptance inserts a full RD_LOW+RD_HIGH strobe before the real one.
//    - cs stays low throughout; dummy data is discarded, no rvalid_o for it.
//    - busy length becomes 1+2*(RD_LOW_CYC+RD_HIGH_CYC).
//  LCD_RD_DUMMY_EN undefined: dummy_i ignored; single strobe always.
// TESTING
//  1 reset: rstn=0 -> cs=1, rd=1, oe=1, busy=0, rvalid=0, rdata=0.
//  2 single read: rs_i=1, lcd_db_i=16'hA5C3 -> rd low 3 cyc, busy 6 cyc, rvalid 1 cyc, rdata=A5C3.
//  3 back-to-back: rs_i=0 then 1, req held high, db=0x0011/0x2222 -> two rvalids 7 cyc apart, lcd_rs 0 then 1.
//  4 req during busy: pulse req_i mid-RD_LOW -> ignored, exactly one rvalid.
//  5 reset mid-op: rstn low in RD_HIGH -> cs=1, rd=1 immediately, no rvalid after release.
//  6 dummy (macro on): dummy_i=1, db=0xDEAD then 0xBEEF -> two rd strobes, cs low across both.
//    Single rvalid with rdata=BEEF; macro off -> one strobe, rdata=DEAD.

Source files
------------

// File: rtl/lcd_read_ctrl.sv
// 8080-style LCD read-cycle controller: drives cs/rd/rs, samples lcd_db_i, returns data to the bridge.
// Optional dummy-read prefix strobe enabled by defining LCD_RD_DUMMY_EN.
//
// state   | meaning
// IDLE    | bus released, waiting for req_i
// SETUP   | cs low, rs driven, pads turned around, rd still high
// RD_LOW  | rd low for RD_LOW_CYC cycles, data sampled on the last edge
// RD_HIGH | rd high for RD_HIGH_CYC cycles, then commit or repeat for dummy
module lcd_read_ctrl #(
  parameter int DATA_W      = 16,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              rs_i,
  input  logic              dummy_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic [DATA_W-1:0] lcd_db_i,
  output logic              lcd_db_oe_o,
  output logic              lcd_cs,
  output logic              lcd_rd,
  output logic              lcd_rs
);

`ifdef LCD_RD_DUMMY_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif

  localparam int MAX_CYC = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(RD_HIGH_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, RD_LOW, RD_HIGH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dummy_q, dummy_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               cs_d, rd_d, rs_d, oe_d, busy_d, rvalid_d;
  logic [DATA_W-1:0]  rdata_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dummy_q     <= 1'b0;
      cap_q       <= '0;
      lcd_cs      <= 1'b1;
      lcd_rd      <= 1'b1;
      lcd_rs      <= 1'b1;
      lcd_db_oe_o <= 1'b1;
      busy_o      <= 1'b0;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dummy_q     <= dummy_d;
      cap_q       <= cap_d;
      lcd_cs      <= cs_d;
      lcd_rd      <= rd_d;
      lcd_rs      <= rs_d;
      lcd_db_oe_o <= oe_d;
      busy_o      <= busy_d;
      rvalid_o    <= rvalid_d;
      rdata_o     <= rdata_d;
    end
  end

  // Next-state and next-output logic; outputs are registered one edge later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dummy_d  = dummy_q;
    cap_d    = cap_q;
    cs_d     = lcd_cs;
    rd_d     = lcd_rd;
    rs_d     = lcd_rs;
    oe_d     = lcd_db_oe_o;
    busy_d   = busy_o;
    rvalid_d = 1'b0;
    rdata_d  = rdata_o;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = SETUP;
          dummy_d = dummy_i & DUMMY_EN;
          rs_d    = rs_i;
          cs_d    = 1'b0;
          oe_d    = 1'b0;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d = RD_LOW;
        cnt_d   = LOW_LOAD;
        rd_d    = 1'b0;
      end
      RD_LOW: begin
        if (cnt_q == '0) begin
          state_d = RD_HIGH;
          cnt_d   = HIGH_LOAD;
          cap_d   = lcd_db_i;
          rd_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (dummy_q) begin
          // Dummy strobe done: its capture is simply overwritten by the real one.
          state_d = RD_LOW;
          dummy_d = 1'b0;
          cnt_d   = LOW_LOAD;
          rd_d    = 1'b0;
        end else begin
          state_d  = IDLE;
          cs_d     = 1'b1;
          oe_d     = 1'b1;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed self-checking bench for lcd_read_ctrl at default parameters.
// Expectations for the dummy-read case follow LCD_RD_DUMMY_EN.
module tb_lcd_read_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req_i, rs_i, dummy_i;
  logic        busy_o, rvalid_o, lcd_db_oe_o, lcd_cs, lcd_rd, lcd_rs;
  logic [15:0] rdata_o, lcd_db_i;

  int passed = 0;
  int total  = 0;

  int n_busy, n_rdlow, n_rv, n_strobe, n_cs_low, rv1, rv2, rs_a, rs_b;
  logic [15:0] rd_seen, rd_seen2;
  logic prev_rd;

  lcd_read_ctrl #(.DATA_W(16), .RD_LOW_CYC(3), .RD_HIGH_CYC(2)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .rs_i(rs_i), .dummy_i(dummy_i),
    .busy_o(busy_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .lcd_db_i(lcd_db_i),
    .lcd_db_oe_o(lcd_db_oe_o), .lcd_cs(lcd_cs), .lcd_rd(lcd_rd), .lcd_rs(lcd_rs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_busy = 0; n_rdlow = 0; n_rv = 0; n_strobe = 0; n_cs_low = 0;
    rv1 = -1; rv2 = -1; rd_seen = '0; rd_seen2 = '0; prev_rd = 1'b1;
  endtask

  task automatic sample(input int i);
    if (busy_o) n_busy++;
    if (!lcd_rd) n_rdlow++;
    if (!lcd_cs) n_cs_low++;
    if (prev_rd && !lcd_rd) n_strobe++;
    prev_rd = lcd_rd;
    if (rvalid_o) begin
      n_rv++;
      if (rv1 < 0) begin rv1 = i; rd_seen = rdata_o; end
      else begin rv2 = i; rd_seen2 = rdata_o; end
    end
  endtask

  initial begin
    rstn = 1'b0; req_i = 1'b0; rs_i = 1'b0; dummy_i = 1'b0; lcd_db_i = 16'h0000;
    // 1: reset state
    #12;
    chk("rst_cs", lcd_cs, 1);
    chk("rst_rd", lcd_rd, 1);
    chk("rst_rs", lcd_rs, 1);
    chk("rst_oe", lcd_db_oe_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    rstn = 1'b1;
    step();

    // 2: single GRAM read
    req_i = 1'b1; rs_i = 1'b1; lcd_db_i = 16'hA5C3;
    step();
    req_i = 1'b0; rs_i = 1'b0;
    chk("setup_busy", busy_o, 1);
    chk("setup_cs", lcd_cs, 0);
    chk("setup_rd", lcd_rd, 1);
    chk("setup_oe", lcd_db_oe_o, 0);
    chk("setup_rs", lcd_rs, 1);
    clr_counts();
    for (int i = 0; i < 12; i++) begin sample(i); step(); end
    chk("single_rdlow", n_rdlow, 3);
    chk("single_busy", n_busy, 6);
    chk("single_rvcnt", n_rv, 1);
    chk("single_rvidx", rv1, 6);
    chk("single_rdata", rd_seen, 16'hA5C3);
    chk("idle_cs", lcd_cs, 1);
    chk("idle_oe", lcd_db_oe_o, 1);

    // 3: back-to-back with req held high
    req_i = 1'b1; rs_i = 1'b0; lcd_db_i = 16'h0011;
    step();
    rs_i = 1'b1;
    clr_counts();
    rs_a = -1; rs_b = -1;
    for (int i = 0; i < 18; i++) begin
      sample(i);
      if (i == 2) rs_a = lcd_rs;
      if (i == 9) rs_b = lcd_rs;
      if (i == 6) lcd_db_i = 16'h2222;
      if (i == 7) req_i = 1'b0;
      step();
    end
    chk("b2b_rvcnt", n_rv, 2);
    chk("b2b_gap", rv2 - rv1, 7);
    chk("b2b_rs_first", rs_a, 0);
    chk("b2b_rs_second", rs_b, 1);
    chk("b2b_data_first", rd_seen, 16'h0011);
    chk("b2b_data_second", rd_seen2, 16'h2222);

    // 4: req pulse during RD_LOW is ignored
    lcd_db_i = 16'h3C3C; req_i = 1'b1;
    step();
    req_i = 1'b0;
    clr_counts();
    for (int i = 0; i < 16; i++) begin
      sample(i);
      req_i = (i == 2);
      step();
    end
    req_i = 1'b0;
    chk("ignore_rvcnt", n_rv, 1);
    chk("ignore_busy", n_busy, 6);
    chk("ignore_rdata", rd_seen, 16'h3C3C);

    // 5: reset in RD_HIGH
    lcd_db_i = 16'h7777; req_i = 1'b1;
    step();
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_pre_rd", lcd_rd, 1);
    chk("midrst_pre_cs", lcd_cs, 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_cs", lcd_cs, 1);
    chk("midrst_rd", lcd_rd, 1);
    chk("midrst_oe", lcd_db_oe_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rdata", rdata_o, 0);
    #3 rstn = 1'b1;
    clr_counts();
    step();
    for (int i = 0; i < 10; i++) begin sample(i); step(); end
    chk("midrst_no_rvalid", n_rv, 0);
    chk("midrst_no_busy", n_busy, 0);

    // 6: dummy read request
    lcd_db_i = 16'hDEAD; dummy_i = 1'b1; rs_i = 1'b1; req_i = 1'b1;
    step();
    req_i = 1'b0; dummy_i = 1'b0;
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      sample(i);
      if (i == 5) lcd_db_i = 16'hBEEF;
      step();
    end
    chk("dummy_rvcnt", n_rv, 1);
    chk("dummy_cs_span", n_cs_low, n_busy);
`ifdef LCD_RD_DUMMY_EN
    chk("dummy_strobes", n_strobe, 2);
    chk("dummy_busy", n_busy, 11);
    chk("dummy_rdata", rd_seen, 16'hBEEF);
`else
    chk("dummy_strobes", n_strobe, 1);
    chk("dummy_busy", n_busy, 6);
    chk("dummy_rdata", rd_seen, 16'hDEAD);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
